// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-buffered UART transmitter with configurable frame format.
//
// Words written into a small TX FIFO are sent as UART frames:
//   start (0), DATA_W data bits LSB first, optional parity, STOP_BITS stop (1).
// Each bit lasts DIV = CLK_FREQ/BAUD clocks. Frames are sent back to back
// while tx_en=1 and the FIFO has data.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active low
//   tx_en      : 1 allows a new frame to start (never aborts a running frame)
//   wr_en      : FIFO write strobe (dropped while full, which sets overflow)
//   wr_data    : word to transmit
//   full/empty : FIFO occupancy flags, decoded from the registered count
//   overflow   : sticky, set by a dropped write, cleared by reset only
//   serial_out : registered UART line, idle high
//   busy       : transmitter not idle
//   baud_tick  : pulse on the last clock of every bit period
//   frame_done : pulse on the last clock of the final stop bit
module uart_tx_param #(
    parameter int CLK_FREQ   = 66000000,
    parameter int BAUD       = 9600,
    parameter int DATA_W     = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              serial_out,
    output logic              busy,
    output logic              baud_tick,
    output logic              frame_done
);
    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int AW   = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = AW + 1;
    localparam int BW   = $clog2(DATA_W);

    localparam logic [CW-1:0]   DIV_LAST = CW'(DIV - 1);
    localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(FIFO_DEPTH);
    localparam logic [BW-1:0]   BIT_LAST = BW'(DATA_W - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_tx_param: CLK_FREQ/BAUD must be at least 2");
        end
        if (DATA_W < 5 || DATA_W > 9) begin : g_bad_width
            $error("uart_tx_param: DATA_W must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_param: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx_param: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_param: FIFO_DEPTH must be a power of 2, at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
    } state_e;

    // ---------------- TX FIFO ----------------
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]   count_q, count_d;
    logic              ovf_q;
    logic              wr_ok, pop;
    logic [DATA_W-1:0] head;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign overflow = ovf_q;
    assign wr_ok    = wr_en && !full;
    assign head     = mem[rd_ptr_q];

    // Pop only ever happens with count > 0, so write-to-empty and pop never coincide.
    always_comb begin
        count_d = count_q;
        if (wr_ok && !pop)      count_d = count_q + 1'b1;
        else if (!wr_ok && pop) count_d = count_q - 1'b1;
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_ok)         wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)           rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_en && full) ovf_q    <= 1'b1;
            count_q <= count_d;
        end
    end

    // ---------------- Transmitter FSM ----------------
    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;      // clock within the current bit
    logic [BW-1:0]     bit_q, bit_d;      // data bit index, reused as stop bit index
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              line_q, line_d;
    logic              tick, last_stop, can_start;

    assign tick       = (state_q != ST_IDLE) && (cnt_q == DIV_LAST);
    assign last_stop  = (STOP_BITS == 1) || (bit_q == BW'(1));
    assign can_start  = tx_en && !empty;
    assign busy       = (state_q != ST_IDLE);
    assign baud_tick  = tick;
    assign serial_out = line_q;

    // line_d is the value the line takes for the state being entered, so the
    // registered line stays aligned with state_q and the bit counter.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        line_d     = line_q;
        pop        = 1'b0;
        frame_done = 1'b0;
        if (state_q != ST_IDLE) cnt_d = tick ? '0 : cnt_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                line_d = 1'b1;
                if (can_start) pop = 1'b1;
            end
            ST_START: if (tick) begin
                state_d = ST_DATA;
                bit_d   = '0;
                line_d  = shift_q[0];
            end
            ST_DATA: if (tick) begin
                if (bit_q == BIT_LAST) begin
                    bit_d = '0;
                    if (PARITY != 0) begin
                        state_d = ST_PARITY;
                        line_d  = par_q;
                    end else begin
                        state_d = ST_STOP;
                        line_d  = 1'b1;
                    end
                end else begin
                    bit_d   = bit_q + 1'b1;
                    shift_d = shift_q >> 1;
                    line_d  = shift_q[1];
                end
            end
            ST_PARITY: if (tick) begin
                state_d = ST_STOP;
                line_d  = 1'b1;
            end
            ST_STOP: if (tick) begin
                if (last_stop) begin
                    frame_done = 1'b1;
                    state_d    = ST_IDLE;
                    line_d     = 1'b1;
                    if (can_start) pop = 1'b1;  // chain the next frame with no idle gap
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Frame is captured here; later FIFO writes cannot touch it.
        if (pop) begin
            state_d = ST_START;
            cnt_d   = '0;
            bit_d   = '0;
            shift_d = head;
            par_d   = (^head) ^ (PARITY == 2);
            line_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            line_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            line_q  <= line_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four instances (different parity/stop formats)
// share one stimulus stream. A frame-level reference model (FIFO occupancy
// count, remaining-clocks-in-frame countdown, expected word queue) runs on
// the inputs; a monitor checks every frame waveform and the status flags.
module tb_uart_tx_param;
    localparam int NDUT  = 4;
    localparam int DIV   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_en = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [NDUT-1:0] full, empty, ovf, ser, busy, tick, fd;

    always #5 clk = ~clk;

    function automatic int par_of(int k);
        return (k == 0) ? 0 : ((k == 2) ? 2 : 1);
    endfunction
    function automatic int stop_of(int k);
        return (k == 3) ? 2 : 1;
    endfunction
    function automatic int len_of(int k);
        return (1 + 8 + ((par_of(k) != 0) ? 1 : 0) + stop_of(k)) * DIV;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        uart_tx_param #(
            .CLK_FREQ(160000), .BAUD(10000), .DATA_W(8),
            .PARITY(g == 0 ? 0 : (g == 2 ? 2 : 1)),
            .STOP_BITS(g == 3 ? 2 : 1), .FIFO_DEPTH(DEPTH)
        ) u_dut (
            .clk(clk), .rst(rst), .tx_en(tx_en), .wr_en(wr_en), .wr_data(wr_data),
            .full(full[g]), .empty(empty[g]), .overflow(ovf[g]),
            .serial_out(ser[g]), .busy(busy[g]), .baud_tick(tick[g]),
            .frame_done(fd[g])
        );
    end

    // ---------------- reference model ----------------
    int         cnt_m [NDUT];   // words waiting in the FIFO
    int         rem   [NDUT];   // clocks left in the frame on the line, 0 = idle
    bit         ovf_m [NDUT];
    logic [7:0] sb    [NDUT][$]; // expected frames, in write order

    initial begin
        int pre;
        forever begin
            @(posedge clk or negedge rst);
            for (int k = 0; k < NDUT; k++) begin
                if (!rst) begin
                    cnt_m[k] = 0;
                    rem[k]   = 0;
                    ovf_m[k] = 1'b0;
                    sb[k].delete();
                end else begin
                    pre = cnt_m[k];
                    if (tx_en && pre > 0 && rem[k] <= 1) begin
                        cnt_m[k]--;
                        rem[k] = len_of(k);
                    end else if (rem[k] > 0) begin
                        rem[k]--;
                    end
                    if (wr_en) begin
                        if (pre == DEPTH) ovf_m[k] = 1'b1;
                        else begin
                            cnt_m[k]++;
                            sb[k].push_back(wr_data);
                        end
                    end
                end
            end
        end
    end

    function automatic logic [12:0] frame_bits(logic [7:0] w, int k);
        logic [12:0] f;
        int ones;
        f = '1;
        f[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = w[i];
            ones += int'(w[i]);
        end
        if (par_of(k) == 1)      f[9] = (ones % 2 == 1);
        else if (par_of(k) == 2) f[9] = (ones % 2 == 0);
        return f;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  final_req = 1'b0;
    bit  final_done = 1'b0;
    bit  drain_to = 1'b0;

    task automatic check(input string nm, input int k, input logic [6:0] act, input logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d @%0t: got %b, expected %b", nm, k, $time, act, exp);
        end
    endtask

    initial begin
        logic [12:0] exp_f [NDUT];
        logic [12:0] got_f [NDUT];
        logic [7:0]  word  [NDUT];
        int          first_bad [NDUT];
        logic [6:0]  last_act [NDUT], last_exp [NDUT];
        bit          first [NDUT];
        logic [6:0]  act, exp;
        logic        e_line, e_tick, e_fd;
        int          pos, len;
        bit          idle;
        for (int k = 0; k < NDUT; k++) begin
            first[k] = 1'b1;
            first_bad[k] = -1;
            exp_f[k] = '1;
            got_f[k] = '1;
            word[k] = '0;
            last_act[k] = '0;
            last_exp[k] = '0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                if (!rst) begin
                    check("reset", k, {ser[k], busy[k], empty[k], full[k], ovf[k], tick[k], fd[k]}, 7'b1010000);
                    first[k] = 1'b1;
                    continue;
                end
                len  = len_of(k);
                idle = (rem[k] == 0);
                if (!idle) begin
                    pos = len - rem[k];
                    if (pos == 0) begin
                        word[k] = (sb[k].size() > 0) ? sb[k].pop_front() : 8'hxx;
                        exp_f[k] = frame_bits(word[k], k);
                        got_f[k] = '1;
                        first_bad[k] = -1;
                    end
                    e_line = exp_f[k][pos / DIV];
                    e_tick = (pos % DIV == DIV - 1);
                    e_fd   = (pos == len - 1);
                    if ({ser[k], tick[k], fd[k]} !== {e_line, e_tick, e_fd} && first_bad[k] < 0)
                        first_bad[k] = pos;
                    if (pos % DIV == DIV / 2) got_f[k][pos / DIV] = ser[k];
                    if (pos == len - 1) begin
                        n_cmp++;
                        if (first_bad[k] >= 0) begin
                            n_bad++;
                            $display("FAIL frame dut%0d word %h: got bits %b, expected %b, first bad clock %0d",
                                     k, word[k], got_f[k], exp_f[k], first_bad[k]);
                        end
                    end
                end
                act = {busy[k], empty[k], full[k], ovf[k],
                       idle ? ser[k] : 1'b1, idle ? tick[k] : 1'b0, idle ? fd[k] : 1'b0};
                exp = {!idle, cnt_m[k] == 0, cnt_m[k] == DEPTH, ovf_m[k], 3'b100};
                if (first[k] || act !== last_act[k] || exp !== last_exp[k])
                    check("status{busy,empty,full,ovf,line,tick,done}", k, act, exp);
                first[k] = 1'b0;
                last_act[k] = act;
                last_exp[k] = exp;
            end
            if (final_req && !final_done) begin
                check("drain_timeout", 0, {6'd0, drain_to}, 7'd0);
                for (int k = 0; k < NDUT; k++)
                    check("frames_not_sent", k, 7'(sb[k].size()), 7'd0);
                final_done = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit we, input logic [7:0] d, input bit en);
        wr_en = we;
        wr_data = d;
        tx_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_n(input int n, input bit en);
        repeat (n) cyc(1'b0, 8'h00, en);
    endtask

    function automatic bit model_idle();
        for (int k = 0; k < NDUT; k++)
            if (rem[k] != 0 || cnt_m[k] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain();
        int i;
        for (i = 0; i < 4000; i++) begin
            if (model_idle()) break;
            cyc(1'b0, 8'h00, 1'b1);
        end
        if (i == 4000) drain_to = 1'b1;
        idle_n(3, 1'b1);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        wr_en = 1'b0;
        tx_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        idle_n(2, 1'b1);

        // single frames, including the parity reference words
        cyc(1'b1, 8'h75, 1'b1); drain();
        cyc(1'b1, 8'h33, 1'b1); drain();
        cyc(1'b1, 8'h79, 1'b1); drain();

        // back to back
        cyc(1'b1, 8'h75, 1'b1);
        cyc(1'b1, 8'h33, 1'b1);
        cyc(1'b1, 8'h79, 1'b1);
        drain();

        // overflow with transmission held off, then release
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
        idle_n(4, 1'b0);
        drain();

        // tx_en dropped inside the first of two queued frames
        cyc(1'b1, 8'hC3, 1'b1);
        cyc(1'b1, 8'h5A, 1'b1);
        idle_n(39, 1'b1);
        idle_n(400, 1'b0);
        drain();

        // random traffic, including writes against a full FIFO
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 5) == 0, 8'($urandom), $urandom_range(0, 7) != 0);
        drain();

        // reset in the middle of a frame with more words queued, then write right away
        cyc(1'b1, 8'h96, 1'b1);
        cyc(1'b1, 8'h0F, 1'b1);
        idle_n(50, 1'b1);
        pulse_reset();
        cyc(1'b1, 8'h3C, 1'b1);
        drain();

        final_req = 1'b1;
        repeat (3) @(posedge clk);
        if (!final_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL final_checks: got not run, expected run");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion by %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 66000000, meaning input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, meaning line bit rate in bits/s.
REQ-003 The block SHALL have parameter DATA_W, default 8, meaning data bits per frame; legal range is 5..9.
REQ-004 The block SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = even, 2 = odd.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values are 1 and 2.
REQ-006 The block SHALL have parameter FIFO_DEPTH, default 4, meaning TX FIFO entries; legal values are powers of 2 and at least 2.
REQ-007 The block SHALL have port clk, input, 1 bit, meaning the single clock; all logic is rising-edge.
REQ-008 The block SHALL have port rst, input, 1 bit, meaning asynchronous, active-low reset.
REQ-009 The block SHALL have port tx_en, input, 1 bit, meaning that 1 permits the start of new frames.
REQ-010 The block SHALL have port wr_en, input, 1 bit, meaning a FIFO write strobe.
REQ-011 The block SHALL have port wr_data, input, DATA_W bits, meaning the byte/word to transmit.
REQ-012 The block SHALL have port full, output, 1 bit, meaning the FIFO holds FIFO_DEPTH entries.
REQ-013 The block SHALL have port empty, output, 1 bit, meaning the FIFO holds 0 entries.
REQ-014 The block SHALL have port overflow, output, 1 bit, meaning a sticky flag set by a dropped write.
REQ-015 The block SHALL have port serial_out, output, 1 bit, meaning the registered UART line, idle high.
REQ-016 The block SHALL have port busy, output, 1 bit, meaning the FSM is not in IDLE.
REQ-017 The block SHALL have port baud_tick, output, 1 bit, meaning a one-clock pulse on the last clock of each bit period.
REQ-018 The block SHALL have port frame_done, output, 1 bit, meaning a one-clock pulse on the last clock of the final stop bit.

Function
REQ-019 The bit period SHALL be DIV = CLK_FREQ/BAUD clocks, using integer truncation; DIV < 2 SHALL be rejected at elaboration.
REQ-020 A write SHALL be accepted when wr_en=1 and full=0 at the clock edge; the FIFO count SHALL increment and full/empty SHALL update after that edge.
REQ-021 A write with wr_en=1 while full=1 SHALL be dropped and SHALL set overflow=1; overflow SHALL be cleared only by reset.
REQ-022 full SHALL be evaluated on the registered count; a write while full is dropped even if a pop occurs on the same edge.
REQ-023 A simultaneous write and pop with 0 < count < FIFO_DEPTH SHALL leave the count unchanged.
REQ-024 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 The FSM SHALL have exactly the states IDLE, START, DATA, PARITY and STOP.
REQ-026 In IDLE, when tx_en=1 and empty=0, the block SHALL pop the head entry into the shift register, enter START, and clear the bit counter on the same edge.
REQ-027 serial_out SHALL go low on the edge after the one at which a write to an empty, idle FIFO is accepted; this is 1-clock latency from the write edge.
REQ-028 START SHALL drive 0 for DIV clocks.
REQ-029 DATA SHALL drive DATA_W bits, LSB first, DIV clocks each.
REQ-030 PARITY SHALL be entered only when PARITY != 0, driving one bit for DIV clocks.
REQ-031 Even parity SHALL drive the XOR of the data bits; odd parity SHALL drive the inverse of that XOR.
REQ-032 STOP SHALL drive 1 for STOP_BITS*DIV clocks.
REQ-033 At STOP end, frame_done SHALL pulse; if tx_en=1 and empty=0, the block SHALL pop and enter START directly, with no idle clocks between frames; otherwise it SHALL enter IDLE.
REQ-034 Deasserting tx_en mid-frame SHALL NOT abort the frame; only the next start SHALL be inhibited.
REQ-035 baud_tick SHALL be 0 in IDLE.
REQ-036 The shift-register contents SHALL be captured at pop; later FIFO writes SHALL NOT alter the frame in flight.

Reset
REQ-037 While rst=0, the block SHALL asynchronously force: serial_out=1, busy=0, empty=1, full=0, overflow=0, baud_tick=0, frame_done=0, state IDLE, pointers, count and counters 0.
REQ-038 Reset mid-frame SHALL discard the frame in flight and all FIFO contents; the line SHALL return high immediately.
REQ-039 After rst rises, the first write SHALL be accepted on the next clock edge.

Verification (CLK_FREQ=160000, BAUD=10000 -> DIV=16)
REQ-040 Reset scenario: pulse rst=0 for 3 clk mid-frame -> serial_out=1 within the same clock phase, empty=1, busy=0, overflow=0.
REQ-041 Basic frame scenario (PARITY=0, STOP_BITS=1): write 8'h75 once -> line 0 for 16 clk, then bits 1,0,1,0,1,1,1,0 for 16 clk each, then 1 for 16 clk; 160 clk total; frame_done pulses on clk 160; 10 baud_ticks.
REQ-042 Parity scenario: PARITY=1 with 8'h33 -> parity bit 0; PARITY=1 with 8'h79 -> parity bit 1; PARITY=2 with 8'h79 -> parity bit 0; frame length 176 clk.
REQ-043 Back-to-back scenario: write 8'h75, 8'h33, 8'h79 on consecutive clocks -> three contiguous frames, 480 clk, no high gap beyond the stop bits, busy=1 throughout, 3 frame_done pulses.
REQ-044 Overflow scenario (FIFO_DEPTH=4, tx_en=0): write 5 words -> full=1 after 4th, 5th dropped, overflow=1; then tx_en=1 -> exactly 4 frames in write order, then empty=1, busy=0.
REQ-045 tx_en-inhibit scenario: 2 words queued, drop tx_en at clk 40 of frame 1 -> frame 1 completes intact, line stays high, empty=0 until tx_en returns to 1.
